// File: rtl/isqrt_seq.sv
// Sequential integer square root using the digit-by-digit restoring method.
// Each enabled cycle consumes the top two operand bits and produces one root bit.
// The result is held on root/rem with a valid/ready handshake.
module isqrt_seq #(
    parameter int DATA_WIDTH = 11
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*DATA_WIDTH-1:0]   data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     root,
    output logic [DATA_WIDTH:0]       rem,
    output logic                      busy
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  x_q, x_d;
    logic [W-1:0]    q_q, q_d;
    logic [W+1:0]    r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    root_q, root_d;
    logic [W:0]      rem_q, rem_d;
    logic            out_valid_q, out_valid_d;

    logic            accept;
    logic            step;
    logic            last;
    logic [W+1:0]    r_sh;
    logic [W+1:0]    t;
    logic [W+1:0]    r_new;
    logic            ge;

    // The partial remainder never exceeds W bits between steps, so only its
    // low W bits feed the next shift; the top two bits are kept for width only.
    logic            unused_r_top;
    assign unused_r_top = ^r_q[W+1:W];

    // One restoring step: trial-subtract {q,01} from the remainder shifted by two bits
    always_comb begin
        r_sh  = {r_q[W-1:0], x_q[2*W-1:2*W-2]};
        t     = {q_q, 2'b01};
        ge    = (r_sh >= t);
        r_new = ge ? (r_sh - t) : r_sh;
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)    state_d = CALC;
            CALC:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM-decoded outputs and control strobes
    always_comb begin
        in_ready = (state_q == IDLE) & en;
        busy     = (state_q == CALC);
        accept   = in_valid & in_ready;
        step     = (state_q == CALC) & en;
        last     = step & (cnt_q == CNT_LAST);
    end

    // Datapath next-state: operand shift, partial root/remainder, result capture
    always_comb begin
        x_d         = x_q;
        q_d         = q_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        root_d      = root_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            x_d   = data;
            q_d   = '0;
            r_d   = '0;
            cnt_d = '0;
        end else if (step) begin
            x_d   = {x_q[2*W-3:0], 2'b00};
            q_d   = {q_q[W-2:0], ge};
            r_d   = r_new;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                root_d      = {q_q[W-2:0], ge};
                rem_d       = r_new[W:0];
                out_valid_d = 1'b1;
            end
        end else if ((state_q == DONE) && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            q_q         <= q_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign root      = root_q;
    assign rem       = rem_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed and randomised checks for isqrt_seq: reset values, table of known
// roots, backpressure, enable stalls, reset abort and a reference-model sweep.
module tb_isqrt_seq;

    localparam int W = 11;

    logic            clk;
    logic            rstn;
    logic            en;
    logic            in_valid;
    logic            in_ready;
    logic [2*W-1:0]  data;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    root;
    logic [W:0]      rem;
    logic            busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2*W-1:0] x;
        int             exp_root;
        int             exp_rem;
    } vec_t;

    vec_t vecs[12];

    isqrt_seq #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .root      (root),
        .rem       (rem),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference root by linear search; independent of the digit recurrence.
    function automatic int ref_root(input longint x);
        longint r;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return int'(r);
    endfunction

    // Issue one operand and check its result. Called and returns at a negedge.
    // en is dropped for stall_len cycles starting at stall_at edges after accept;
    // out_ready is held low for hold cycles after out_valid rises.
    task automatic apply(input string name, input logic [2*W-1:0] x,
                         input int exp_root, input int exp_rem,
                         input int stall_at, input int stall_len,
                         input int hold, input int exp_wait);
        int w;
        int lat;
        out_ready = (hold == 0);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (exp_wait >= 0) chk({name, " accept_wait"}, w, exp_wait);
        if (!in_ready) begin
            chk({name, " in_ready_timeout"}, 0, 1);
            return;
        end
        in_valid = 1'b1;
        data     = x;
        @(negedge clk);
        in_valid = 1'b0;
        data     = 22'($urandom);
        chk({name, " busy_after_accept"}, busy, 1);
        lat = 0;
        en  = !(lat >= stall_at && lat < stall_at + stall_len);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (!out_valid) begin
                if (!en) chk({name, " busy_in_stall"}, busy, 1);
                en = !(lat >= stall_at && lat < stall_at + stall_len);
            end
        end
        en = 1'b1;
        chk({name, " latency"}, lat, W + stall_len);
        chk({name, " root"}, root, exp_root);
        chk({name, " rem"}, rem, exp_rem);
        repeat (hold) begin
            @(negedge clk);
            chk({name, " held_valid"}, out_valid, 1);
            chk({name, " held_root"}, root, exp_root);
            chk({name, " held_rem"}, rem, exp_rem);
            chk({name, " held_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, " valid_cleared"}, out_valid, 0);
        chk({name, " idle_in_ready"}, in_ready, 1);
        chk({name, " root_kept"}, root, exp_root);
    endtask

    initial begin
        bit saw_valid;
        vecs[0]  = '{22'd144,     12,   0};
        vecs[1]  = '{22'd145,     12,   1};
        vecs[2]  = '{22'd2,       1,    1};
        vecs[3]  = '{22'd0,       0,    0};
        vecs[4]  = '{22'd4194303, 2047, 4094};
        vecs[5]  = '{22'd1,       1,    0};
        vecs[6]  = '{22'd3,       1,    2};
        vecs[7]  = '{22'd1048576, 1024, 0};
        vecs[8]  = '{22'd1000000, 1000, 0};
        vecs[9]  = '{22'd999999,  999,  1998};
        vecs[10] = '{22'd4190208, 2046, 4092};
        vecs[11] = '{22'd99,      9,    18};

        rstn      = 1'b1;
        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data      = '0;
        #1 rstn = 1'b0;
        #2;
        chk("reset root", root, 0);
        chk("reset rem", rem, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset in_ready en1", in_ready, 1);
        en = 1'b0;
        #1 chk("reset in_ready en0", in_ready, 0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Table of known roots, no stalls, no backpressure
        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].x, vecs[i].exp_root, vecs[i].exp_rem,
                  -1, 0, 0, 0);
        end

        // Backpressure: result held 5 cycles, next operand accepted with no extra wait
        apply("bp_first", 22'd145, 12, 1, -1, 0, 5, 0);
        apply("bp_second", 22'd144, 12, 0, -1, 0, 0, 0);

        // Enable stall of 3 cycles mid-calculation
        apply("stall", 22'd10000, 100, 0, 4, 3, 0, 0);

        // Reset during CALC aborts the operation
        in_valid = 1'b1;
        data     = 22'd12345;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort out_valid", out_valid, 0);
        chk("abort busy", busy, 0);
        chk("abort root", root, 0);
        chk("abort rem", rem, 0);
        @(negedge clk);
        rstn = 1'b1;
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("abort no_valid_pulse", saw_valid, 0);
        apply("after_abort", 22'd99, 9, 18, -1, 0, 0, 0);

        // Randomised operands with random stalls and backpressure
        for (int i = 0; i < 300; i++) begin
            logic [2*W-1:0] x;
            int r;
            int sl;
            x  = 22'($urandom);
            if (i % 50 == 0) x = '1;
            r  = ref_root(longint'(x));
            sl = $urandom_range(0, 3);
            apply($sformatf("rnd%0d", i), x, r, int'(x) - r * r,
                  (sl == 0) ? -1 : int'($urandom_range(0, 9)), sl,
                  $urandom_range(0, 3), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
